// File: rtl/neo_pkg.sv
// Shared types and helpers for the multi-channel Nonlinear Energy Operator engine.
package neo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    NEXTCH,
    FIN
  } neo_state_t;

  // Full-precision psi width: two 2N-bit products plus one bit for the difference.
  function automatic int neo_psi_w(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/neo_window.sv
// 3-tap sample window (x_prev, x_curr, x_next) with synchronous clear and shift enable,
// plus the combinational full-precision psi = x_curr^2 - x_prev*x_next.
module neo_window import neo_pkg::*; #(
  parameter  int N  = 8,
  localparam int PW = neo_psi_w(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift,
  input  logic signed [N-1:0]  din,
  output logic signed [PW-1:0] psi
);

  logic signed [N-1:0]   x_prev_q, x_curr_q, x_next_q;
  logic signed [N-1:0]   x_prev_d, x_curr_d, x_next_d;
  logic signed [2*N-1:0] prev_w, curr_w, next_w;
  logic signed [2*N-1:0] sq_w, cross_w;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    x_prev_d = x_prev_q;
    x_curr_d = x_curr_q;
    x_next_d = x_next_q;
    if (clr) begin
      x_prev_d = '0;
      x_curr_d = '0;
      x_next_d = '0;
    end else if (shift) begin
      x_prev_d = x_curr_q;
      x_curr_d = x_next_q;
      x_next_d = din;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q <= '0;
      x_curr_q <= '0;
      x_next_q <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      x_curr_q <= x_curr_d;
      x_next_q <= x_next_d;
    end
  end

  // Operands are sign-extended to 2N bits first; the exact products always fit there.
  assign prev_w  = $signed({{N{x_prev_q[N-1]}}, x_prev_q});
  assign curr_w  = $signed({{N{x_curr_q[N-1]}}, x_curr_q});
  assign next_w  = $signed({{N{x_next_q[N-1]}}, x_next_q});
  assign sq_w    = curr_w * curr_w;
  assign cross_w = prev_w * next_w;
  assign psi     = $signed({sq_w[2*N-1], sq_w}) - $signed({cross_w[2*N-1], cross_w});

endmodule

// File: rtl/neo_engine.sv
// Multi-channel NEO engine: sweeps C channels of M samples from the sample RAM and writes psi
// to the result RAM. Optional threshold spike counter is enabled by defining NEO_THRESH_EN.
module neo_engine import neo_pkg::*; #(
  parameter  int N  = 8,
  parameter  int M  = 8,
  parameter  int C  = 1,
  localparam int AW = (C * M > 1) ? $clog2(C * M) : 1,
  localparam int PW = neo_psi_w(N)
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        raddr,
  input  logic signed [N-1:0]  rdata,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic signed [PW-1:0] wdata
`ifdef NEO_THRESH_EN
  ,
  input  logic signed [PW-1:0] thresh,
  output logic [AW:0]          spike_cnt,
  output logic                 spike_any
`endif
);

  localparam int MW = $clog2(M);
  localparam int TW = $clog2(M + 4);
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  neo_state_t          state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic signed [PW-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                win_clr, win_shift;
  logic signed [PW-1:0] psi;
  logic [MW-1:0]       k_w;
  logic                in_write, accept;

  neo_window #(.N(N)) u_window (
    .clk   (Clk),
    .rst_n (reset),
    .clr   (win_clr),
    .shift (win_shift),
    .din   (rdata),
    .psi   (psi)
  );

  // Cycle t within a channel computes the write for sample k = t-3 (presented at t+1).
  assign k_w      = MW'(cnt_q - TW'(3));
  assign in_write = ((state_q == READ) || (state_q == DRAIN)) &&
                    (cnt_q >= TW'(3)) && (cnt_q <= TW'(M + 2));
  assign accept   = (state_q == IDLE) && start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    win_clr   = 1'b0;
    win_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
          ch_d    = '0;
          raddr_d = '0;
          busy_d  = 1'b1;
          win_clr = 1'b1;
        end
      end
      READ: begin
        cnt_d     = cnt_q + TW'(1);
        win_shift = (cnt_q != '0);
        if (cnt_q == TW'(M - 1)) state_d = DRAIN;
        else                      raddr_d = raddr_q + AW'(1);
      end
      DRAIN: begin
        cnt_d     = cnt_q + TW'(1);
        win_shift = (cnt_q == TW'(M));
        if (cnt_q == TW'(M + 2)) state_d = NEXTCH;
      end
      NEXTCH: begin
        if (ch_q != CW'(C - 1)) begin
          state_d = READ;
          ch_d    = ch_q + CW'(1);
          cnt_d   = '0;
          raddr_d = raddr_q + AW'(1);
          win_clr = 1'b1;
        end else begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (in_write) begin
      we_d    = 1'b1;
      waddr_d = (AW'(ch_q) << MW) | AW'(k_w);
      // Edge samples have no full neighbourhood and are defined as zero.
      wdata_d = ((k_w == '0) || (k_w == MW'(M - 1))) ? '0 : psi;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign raddr = raddr_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

`ifdef NEO_THRESH_EN
  logic signed [PW-1:0] thresh_q, thresh_d;
  logic [AW:0]          spike_cnt_q, spike_cnt_d;

  // Counts presented writes, so the final count settles on the edge that raises done.
  always_comb begin
    thresh_d    = thresh_q;
    spike_cnt_d = spike_cnt_q;
    if (accept) begin
      thresh_d    = thresh;
      spike_cnt_d = '0;
    end else if (we_q && (wdata_q > thresh_q)) begin
      spike_cnt_d = spike_cnt_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      thresh_q    <= '0;
      spike_cnt_q <= '0;
    end else begin
      thresh_q    <= thresh_d;
      spike_cnt_q <= spike_cnt_d;
    end
  end

  assign spike_cnt = spike_cnt_q;
  assign spike_any = (spike_cnt_q != '0);
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_neo_engine.sv
// Self-checking bench for neo_engine (N=8, M=8, C=2): table-driven vectors with a write
// scoreboard, plus hand-written start-while-busy, rerun and mid-run reset sequences.
module tb_neo_engine;

  localparam int N   = 8;
  localparam int M   = 8;
  localparam int C   = 2;
  localparam int AW  = 4;
  localparam int PW  = 17;
  localparam int RUN = C * (M + 4);
  localparam int NV  = 6;

  logic                 Clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 busy, done, we;
  logic [AW-1:0]        raddr, waddr;
  logic signed [N-1:0]  rdata;
  logic signed [PW-1:0] wdata;
`ifdef NEO_THRESH_EN
  logic signed [PW-1:0] thresh;
  logic [AW:0]          spike_cnt;
  logic                 spike_any;
`endif

  neo_engine #(.N(N), .M(M), .C(C)) dut (
    .Clk   (Clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
`ifdef NEO_THRESH_EN
    ,
    .thresh    (thresh),
    .spike_cnt (spike_cnt),
    .spike_any (spike_any)
`endif
  );

  always #5 Clk = ~Clk;

  // Sample RAM: synchronous read, data valid the cycle after the address.
  logic signed [N-1:0] mem [C*M];
  always @(posedge Clk) rdata <= mem[raddr];

  typedef struct {
    string name;
    int    x[C*M];
    int    psi[C*M];
    int    thr;
    int    spk;
  } vec_t;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_raddr(input int cyc);
    int c, t;
    if (cyc >= RUN) return C * M - 1;
    c = cyc / (M + 4);
    t = cyc % (M + 4);
    return c * M + ((t < M) ? t : M - 1);
  endfunction

  task automatic start_run(input int v);
    for (int i = 0; i < C * M; i++) mem[i] = 8'(vecs[v].x[i]);
`ifdef NEO_THRESH_EN
    thresh = PW'(vecs[v].thr);
`endif
    @(negedge Clk) start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input int v, input bit glitch);
    exp_t  e;
    string nm;
    sb.delete();
    for (int i = 0; i < C * M; i++) begin
      e.addr = i;
      e.data = vecs[v].psi[i];
      e.cyc  = (i / M) * (M + 4) + (i % M) + 4;
      sb.push_back(e);
    end
    nm = glitch ? {vecs[v].name, "+restart"} : vecs[v].name;
    start_run(v);
    for (int cyc = 0; cyc < RUN + 3; cyc++) begin
      @(negedge Clk);
      check($sformatf("%s.busy@%0d", nm, cyc), int'(busy), int'(cyc < RUN));
      check($sformatf("%s.done@%0d", nm, cyc), int'(done), int'(cyc == RUN));
      check($sformatf("%s.raddr@%0d", nm, cyc), int'(raddr), exp_raddr(cyc));
      if (we) begin
        if (sb.size() == 0) begin
          check($sformatf("%s.extra_write@%0d", nm, cyc), 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s.wcyc[%0d]", nm, e.addr), cyc, e.cyc);
          check($sformatf("%s.waddr[%0d]", nm, e.addr), int'(waddr), e.addr);
          check($sformatf("%s.wdata[%0d]", nm, e.addr), int'(wdata), e.data);
        end
      end
`ifdef NEO_THRESH_EN
      if (cyc >= RUN) begin
        check($sformatf("%s.spike_cnt@%0d", nm, cyc), int'(spike_cnt), vecs[v].spk);
        check($sformatf("%s.spike_any@%0d", nm, cyc), int'(spike_any), int'(vecs[v].spk != 0));
      end
      // Threshold must have been captured at acceptance, not tracked live.
      if (cyc == 2) thresh = PW'(-60000);
`endif
      if (glitch && cyc == 3) start = 1'b1;
      if (glitch && cyc == 4) start = 1'b0;
    end
    check($sformatf("%s.writes_missing", nm), sb.size(), 0);
  endtask

  initial begin
    vecs[0].name = "ramp_const_t0";
    vecs[0].x    = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 5, 5, 5, 5, 5, 5, 5};
    vecs[0].psi  = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].thr  = 0;
    vecs[0].spk  = 6;
    vecs[1]      = vecs[0];
    vecs[1].name = "ramp_const_t1";
    vecs[1].thr  = 1;
    vecs[1].spk  = 0;
    vecs[2]      = vecs[0];
    vecs[2].name = "ramp_const_tm1";
    vecs[2].thr  = -1;
    vecs[2].spk  = 16;
    vecs[3].name = "extremes";
    vecs[3].x    = '{-128, 127, -128, 127, -128, 127, -128, 127,
                     127, -128, 127, -128, 127, -128, 127, -128};
    vecs[3].psi  = '{0, -255, 255, -255, 255, -255, 255, 0,
                     0, 255, -255, 255, -255, 255, -255, 0};
    vecs[3].thr  = -1;
    vecs[3].spk  = 10;
    vecs[4].name = "mixed";
    vecs[4].x    = '{3, -2, 7, -8, 1, 0, -5, 4, -1, -1, -1, -1, -1, -1, -1, -1};
    vecs[4].psi  = '{0, -17, 33, 57, 1, 5, 25, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].thr  = 20;
    vecs[4].spk  = 3;
    vecs[5].name = "const_ramp";
    vecs[5].x    = '{5, 5, 5, 5, 5, 5, 5, 5, 0, 1, 2, 3, 4, 5, 6, 7};
    vecs[5].psi  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    vecs[5].thr  = 0;
    vecs[5].spk  = 6;

    reset = 1'b0;
    start = 1'b0;
`ifdef NEO_THRESH_EN
    thresh = '0;
`endif
    repeat (3) @(negedge Clk);
    check("reset.busy",  int'(busy),  0);
    check("reset.done",  int'(done),  0);
    check("reset.we",    int'(we),    0);
    check("reset.raddr", int'(raddr), 0);
    check("reset.waddr", int'(waddr), 0);
    check("reset.wdata", int'(wdata), 0);
    reset = 1'b1;
    repeat (2) @(negedge Clk);

    for (int v = 0; v < NV; v++) run_vec(v, v == 0);
    // Same data again after returning to IDLE must run identically.
    run_vec(0, 1'b0);

    // Mid-run reset while writes are in flight: outputs clear at once, no done follows.
    begin
      int seen;
      start_run(3);
      repeat (7) @(negedge Clk);
      check("midrst.we_before", int'(we), 1);
      #2 reset = 1'b0;
      #1;
      check("midrst.busy",  int'(busy),  0);
      check("midrst.done",  int'(done),  0);
      check("midrst.we",    int'(we),    0);
      check("midrst.wdata", int'(wdata), 0);
      check("midrst.raddr", int'(raddr), 0);
      check("midrst.waddr", int'(waddr), 0);
      @(negedge Clk) reset = 1'b1;
      seen = 0;
      for (int i = 0; i < RUN + 6; i++) begin
        @(negedge Clk);
        if (done || we || busy) seen++;
      end
      check("midrst.no_activity_after", seen, 0);
    end
    run_vec(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
